// File: rtl/uart_cpu_if.sv
// CPU bus bundle for the UART peripheral: single-cycle req strobe, registered ack/rdata.
interface uart_cpu_if;
  logic        req;
  logic        write;
  logic        address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, write, address, wdata, input rdata, ack);
  modport slave  (input req, write, address, wdata, output rdata, ack);
endinterface

// File: rtl/uart_cpu_peripheral.sv
// Byte-wide 8N1 UART with STATUS/DATA CPU registers and a one-byte RX holding register.
// Optional internal TX->RX loopback (STATUS[4]) is enabled by defining UART_LOOPBACK_EN.
module uart_cpu_peripheral #(
  parameter int BIT_CYCLES  = 100,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic      clk,
  input  logic      reset,
  uart_cpu_if.slave bus,
  input  logic      uart_rxd,
  output logic      uart_txd
);

  localparam int CW = $clog2(BIT_CYCLES);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BIT_LAST  = cnt_t'(BIT_CYCLES - 1);
  localparam cnt_t HALF_LAST = cnt_t'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode
  logic rd_status, rd_data, wr_status, wr_data;
  assign rd_status = bus.req & ~bus.write & ~bus.address;
  assign rd_data   = bus.req & ~bus.write &  bus.address;
  assign wr_status = bus.req &  bus.write & ~bus.address;
  assign wr_data   = bus.req &  bus.write &  bus.address;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  logic lb_en;
`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          lb_en <= 1'b0;
    else if (wr_status) lb_en <= bus.wdata[4];
  end
`else
  assign lb_en = 1'b0;
`endif

  // TX path
  tx_state_t  tx_state, tx_state_n;
  cnt_t       tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       tx_line, tx_line_n;
  logic       tx_busy;

  assign tx_busy  = (tx_state != TX_IDLE);
  assign uart_txd = tx_line | lb_en;

  // NOTE: state lives only in always_ff with <=; all next-state logic is always_comb with
  // every output defaulted first, so no latches can be inferred.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    unique case (tx_state)
      TX_IDLE: if (wr_data) begin
        tx_state_n = TX_START;
        tx_cnt_n   = '0;
        tx_shift_n = bus.wdata[7:0];
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_state_n = TX_DATA;
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
      end else tx_cnt_n = tx_cnt + cnt_t'(1);
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        else                tx_bit_n   = tx_bit + 3'd1;
      end else tx_cnt_n = tx_cnt + cnt_t'(1);
      TX_STOP: if (tx_cnt == BIT_LAST) begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
      end else tx_cnt_n = tx_cnt + cnt_t'(1);
      default: tx_state_n = TX_IDLE;
    endcase
    // Line level is registered from the next state so it tracks state changes exactly
    unique case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  // RX path: 2-FF synchroniser plus one delayed copy for falling-edge detection
  logic rx_src, rxd_m, rxd_s, rxd_d;
  assign rx_src = lb_en ? tx_line : uart_rxd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rx_src;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  rx_state_t  rx_state, rx_state_n;
  cnt_t       rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       rx_done_ok, rx_done_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_done_ok  = 1'b0;
    rx_done_err = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (rxd_d & ~rxd_s) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
      // A line already back high at the start-bit mid-point was only a glitch
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_state_n = rxd_s ? RX_IDLE : RX_DATA;
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
      end else rx_cnt_n = rx_cnt + cnt_t'(1);
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rxd_s, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end else rx_cnt_n = rx_cnt + cnt_t'(1);
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_state_n  = RX_IDLE;
        rx_cnt_n    = '0;
        rx_done_ok  = rxd_s;
        rx_done_err = ~rxd_s;
      end else rx_cnt_n = rx_cnt + cnt_t'(1);
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Holding register and sticky flags; a completing byte beats a same-cycle DATA read
  logic [7:0] rx_byte;
  logic       rx_valid, overrun, frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_status && bus.wdata[2]) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rx_done_ok) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_data) overrun <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_done_err) frame_err <= 1'b1;
    end
  end

  logic [31:0] status_word;
  assign status_word = {27'h0, lb_en, frame_err, overrun, rx_valid, tx_busy};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack <= bus.req;
      if (rd_status)    bus.rdata <= status_word;
      else if (rd_data) bus.rdata <= {24'h0, rx_byte};
      else              bus.rdata <= '0;
    end
  end

endmodule

// File: doc/uart_cpu_peripheral.md
Name: uart_cpu_peripheral

Overview:
- Byte-wide UART peripheral mapped at the ID_CPU_UART slot of the CPU bus.
- Serialises CPU-written bytes onto uart_txd and deserialises uart_rxd into a one-byte holding register.
- Bit timing is derived from CLOCK_FREQUENCY / UART_BAUD_RATE (100 MHz / 1 Mbaud = 100 cycles per bit).
- Format is fixed at 8N1, LSB first; the CPU side exposes a STATUS word and a DATA word.

Parameters:
- BIT_CYCLES, 100, clock cycles per UART bit; legal range 8..4095.
- HALF_CYCLES, BIT_CYCLES/2, RX start-bit mid-point delay; integer divide, truncating.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  single-cycle CPU access strobe.
- write  in  1  1 = write, 0 = read; qualified by req.
- address  in  1  0 = STATUS, 1 = DATA.
- wdata  in  32  write data; only [7:0] and [2] are used.
- rdata  out  32  read data; valid while ack = 1.
- ack  out  1  access complete; pulses exactly 1 cycle, 1 cycle after req.
- uart_rxd  in  1  asynchronous serial input, idle high.
- uart_txd  out  1  serial output, idle high.

Behaviour:
- Reset (asynchronous, active-high):
  - uart_txd = 1, ack = 0, rdata = 0.
  - rx_valid = 0, overrun = 0, frame_err = 0.
  - TX FSM = TX_IDLE, RX FSM = RX_IDLE, all counters = 0.
  - Reset mid-frame aborts the frame immediately; uart_txd returns high asynchronously.
- CPU bus:
  - req sampled at edge N; ack = 1 and rdata valid at edge N+1.
  - A req while ack = 1 is legal; it is acked at the next edge, so back-to-back accesses give continuous ack.
  - rdata = 0 whenever ack = 0.
- STATUS word (address 0):
  - Read: [0] tx_busy, [1] rx_valid, [2] overrun, [3] frame_err, [31:4] = 0.
  - Write with wdata[2] = 1 clears overrun and frame_err; the other bits are ignored.
- DATA word (address 1):
  - Write: if tx_busy = 0, wdata[7:0] is latched and TX starts on the next cycle. If tx_busy = 1 the write is silently dropped but still acked.
  - Read: rdata = {24'h0, rx_byte}; clears rx_valid at the ack edge.
- TX FSM: TX_IDLE -> TX_START -> TX_DATA (8 bits) -> TX_STOP -> TX_IDLE.
  - Every state except TX_IDLE lasts exactly BIT_CYCLES cycles, counted by a bit counter from 0 to BIT_CYCLES-1.
  - tx_busy = 1 in every state except TX_IDLE.
  - A frame is 10*BIT_CYCLES cycles from the first low cycle on uart_txd to the end of the stop bit.
  - A DATA write accepted in the cycle tx_busy falls is allowed, giving back-to-back frames.
- RX path:
  - uart_rxd passes through a 2-FF synchroniser; its output is rxd_s. A falling edge on rxd_s in RX_IDLE moves to RX_START.
  - RX_START: wait HALF_CYCLES. If rxd_s = 1 at that point, the edge was a glitch: return to RX_IDLE with no flags changed. Otherwise go to RX_DATA.
  - RX_DATA: sample 8 bits at BIT_CYCLES intervals from the start-bit mid-point, shifting LSB first.
  - RX_STOP: sample at the stop-bit mid-point.
    - rxd_s = 0: set frame_err and discard the byte.
    - rxd_s = 1: write rx_byte and set rx_valid. If rx_valid was already 1, set overrun and overwrite rx_byte with the new byte.
    - Either way, return to RX_IDLE.
  - If a DATA read clears rx_valid in the same cycle a new byte completes, the new byte wins: rx_valid stays 1 and overrun is not set.
  - RX re-arms immediately after the stop-bit sample; rxd_s must be seen high before the next falling edge counts.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - STATUS bit [4] is a read/write loopback enable, reset value 0.
  - When bit [4] = 1, the RX synchroniser input is the internal TX output instead of uart_rxd.
  - uart_txd is held high while loopback is enabled.
- Undefined:
  - STATUS bit [4] reads 0 and writes to it are ignored.
  - RX is always fed from uart_rxd.

Test Plan:
- Reset release, read STATUS -> rdata = 32'h0000_0000 and ack 1 cycle after req; uart_txd = 1.
- Write DATA 32'h0000_00A5 -> uart_txd low for 100 cycles, then bits 1,0,1,0,0,1,0,1 at 100 cycles each, then stop high. tx_busy = 1 for 1000 cycles.
- Drive 8N1 byte 8'h3C on uart_rxd at 100 cycles/bit -> STATUS = 32'h2, then DATA read = 32'h3C, then STATUS = 32'h0.
- Send two bytes 8'h11 and 8'h22 without reading -> STATUS = 32'h6, DATA = 32'h22. A STATUS write of 32'h4 clears it to 32'h2.
- Hold uart_rxd low through the stop bit -> STATUS [3] = 1 and rx_valid stays 0. A 30-cycle low glitch -> no flags change.
- Assert reset mid-TX frame -> uart_txd = 1 asynchronously. After release, tx_busy = 0 and a new write transmits correctly.
